// File: rtl/mem_stage_sized_pkg.sv
// Shared types and helpers for the sized MEM stage: access-size encodings,
// FSM states, and the lane steering / load extension functions.
package mem_stage_sized_pkg;

  localparam int WORD = 32;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic logic is_aligned(input mem_size_e sz, input logic [1:0] off);
    case (sz)
      MEM_H:   return ~off[0];
      MEM_W:   return (off == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_lanes(input mem_size_e sz, input logic [1:0] off);
    case (sz)
      MEM_B:   return 4'b0001 << off;
      MEM_H:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the low lanes so whichever lanes are enabled see the right bytes.
  function automatic logic [WORD-1:0] store_data(input mem_size_e sz, input logic [WORD-1:0] d);
    case (sz)
      MEM_B:   return {4{d[7:0]}};
      MEM_H:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [WORD-1:0] load_extend(input logic [WORD-1:0] w, input mem_size_e sz,
                                                  input logic sgn, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      MEM_B:   return sgn ? {{24{b[7]}}, b} : {24'b0, b};
      MEM_H:   return sgn ? {{16{h[15]}}, h} : {16'b0, h};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_sized_if.sv
// EX/MEM inputs and MEM/WB outputs of the sized MEM stage, bundled as one bus.
interface mem_stage_sized_if import mem_stage_sized_pkg::*; ();
  logic             in_valid;
  logic             zero;
  logic             Branch;
  logic             MemRead;
  logic             MemWrite;
  mem_size_e        MemSize;
  logic             MemSigned;
  logic             RegWrite_in;
  logic             MemtoReg_in;
  logic [4:0]       RegDstAddress_in;
  logic [WORD-1:0]  ALUResult_in;
  logic [WORD-1:0]  MemWriteData;
  logic             stall;
  logic             PCSrc;
  logic             misalign;
  logic             RegWrite_out;
  logic             MemtoReg_out;
  logic [4:0]       RegDstAddress_out;
  logic [WORD-1:0]  MemReadData;
  logic [WORD-1:0]  ALUResult_out;

  modport master (
    output in_valid, zero, Branch, MemRead, MemWrite, MemSize, MemSigned,
           RegWrite_in, MemtoReg_in, RegDstAddress_in, ALUResult_in, MemWriteData,
    input  stall, PCSrc, misalign, RegWrite_out, MemtoReg_out, RegDstAddress_out,
           MemReadData, ALUResult_out
  );

  modport slave (
    input  in_valid, zero, Branch, MemRead, MemWrite, MemSize, MemSigned,
           RegWrite_in, MemtoReg_in, RegDstAddress_in, ALUResult_in, MemWriteData,
    output stall, PCSrc, misalign, RegWrite_out, MemtoReg_out, RegDstAddress_out,
           MemReadData, ALUResult_out
  );
endinterface

// File: rtl/mem_stage_sized_byte_lane_ram.sv
// Data memory built from four byte lanes with per-lane write enables and an
// asynchronous word read. Contents are not reset.
module byte_lane_ram #(
  parameter  int SIZE = 1024,
  localparam int AW   = $clog2(SIZE)
) (
  input  logic          clk,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem [SIZE];

    always_ff @(posedge clk) begin
      if (we_i[i]) mem[addr_i] <= wdata_i[8*i +: 8];
    end

    assign rdata_o[8*i +: 8] = mem[addr_i];
  end

endmodule

// File: rtl/mem_stage_sized.sv
// MEM stage: sized loads/stores with misalignment trap, MEM_LAT-cycle access
// with upstream stall, branch resolution and the MEM/WB register.
module mem_stage_sized import mem_stage_sized_pkg::*; #(
  parameter int SIZE    = 1024,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  mem_stage_sized_if.slave  bus
);

  localparam int AW    = $clog2(SIZE);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             acc, good, trap, is_store, is_load, done, stall_d;
  logic [3:0]       we;
  logic [WORD-1:0]  rdata, wdata, ld_d;

  logic             rw_q, mtr_q, mis_q;
  logic [4:0]       dst_q;
  logic [WORD-1:0]  rdata_q, alu_q;

  assign acc      = bus.in_valid & (bus.MemRead | bus.MemWrite);
  assign good     = acc & is_aligned(bus.MemSize, bus.ALUResult_in[1:0]);
  assign trap     = acc & ~good;
  assign is_store = good & bus.MemWrite;
  assign is_load  = good & bus.MemRead & ~bus.MemWrite;

  always_comb begin
    stall_d = 1'b0;
    done    = 1'b1;
    if (state_q == BUSY) begin
      stall_d = (cnt_q > CNT_W'(1));
      done    = (cnt_q == CNT_W'(1));
    end else begin
      stall_d = good && (MEM_LAT > 1);
      done    = !stall_d;
    end
  end

  // An edge with reset low abandons the access, so its store must not land.
  assign we    = (is_store && done && reset) ? store_lanes(bus.MemSize, bus.ALUResult_in[1:0]) : 4'b0;
  assign wdata = store_data(bus.MemSize, bus.MemWriteData);
  assign ld_d  = is_load ? load_extend(rdata, bus.MemSize, bus.MemSigned, bus.ALUResult_in[1:0])
                         : '0;

  byte_lane_ram #(.SIZE(SIZE)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .addr_i  (bus.ALUResult_in[AW+1:2]),
    .wdata_i (wdata),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      mtr_q   <= 1'b0;
      mis_q   <= 1'b0;
      dst_q   <= '0;
      rdata_q <= '0;
      alu_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (stall_d) begin
          state_q <= BUSY;
          cnt_q   <= CNT_W'(MEM_LAT - 1);
        end
        BUSY: if (done) state_q <= IDLE;
              else      cnt_q   <= cnt_q - 1'b1;
        default: state_q <= IDLE;
      endcase

      if (done) begin
        rw_q    <= bus.in_valid & bus.RegWrite_in & ~trap;
        mtr_q   <= bus.MemtoReg_in;
        mis_q   <= trap;
        dst_q   <= bus.RegDstAddress_in;
        rdata_q <= ld_d;
        alu_q   <= bus.ALUResult_in;
      end else begin
        rw_q    <= 1'b0;
        mtr_q   <= 1'b0;
        mis_q   <= 1'b0;
        dst_q   <= '0;
        rdata_q <= '0;
        alu_q   <= '0;
      end
    end
  end

  assign bus.stall             = stall_d;
  assign bus.PCSrc             = bus.in_valid & bus.Branch & bus.zero;
  assign bus.misalign          = mis_q;
  assign bus.RegWrite_out      = rw_q;
  assign bus.MemtoReg_out      = mtr_q;
  assign bus.RegDstAddress_out = dst_q;
  assign bus.MemReadData       = rdata_q;
  assign bus.ALUResult_out     = alu_q;

endmodule
